// File: rtl/ps2_key_matrix.sv
// ps2_key_matrix: PS/2 scan-code set 2 decoder. It keeps a NUM_KEYS key matrix
// and emits single-cycle press/release events in the system clock domain.
module ps2_key_matrix #(
    parameter int                    NUM_KEYS    = 16,
    parameter int                    KEY_W       = 4,
    parameter logic [NUM_KEYS*9-1:0] KEYMAP      = {9'h02A, 9'h02B, 9'h02D, 9'h025,
                                                    9'h021, 9'h01A, 9'h023, 9'h01B,
                                                    9'h01C, 9'h024, 9'h01D, 9'h015,
                                                    9'h026, 9'h01E, 9'h016, 9'h022},
    parameter int                    TIMEOUT     = 2000000,
    parameter int                    SYNC_STAGES = 2
) (
    input  logic                clk,
    input  logic                res,
    input  logic                ps2_ready,
    input  logic [7:0]          ps2_data,
    input  logic                clear_all,
    output logic [NUM_KEYS-1:0] key_matrix,
    output logic                any_key,
    output logic                ev_valid,
    output logic [KEY_W-1:0]    ev_key,
    output logic                ev_down
);
    // state  | meaning
    // IDLE   | waiting for a make code or a prefix byte
    // BRK    | F0 seen, next byte is a release
    // EXT    | E0 seen, next byte is an extended make or F0
    // EXTBRK | E0 F0 seen, next byte is an extended release
    // SKIP   | inside the E1 Pause sequence, bytes are discarded
    typedef enum logic [2:0] {S_IDLE, S_BRK, S_EXT, S_EXTBRK, S_SKIP} state_t;

    localparam int            TW       = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

    state_t                 state, state_nxt;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                   rdy_prev, rdy_rise;
    logic [7:0]             byte_q;
    logic                   proc_v;
    logic [TW-1:0]          tmo_cnt;
    logic [2:0]             skip_cnt;
    logic                   tmo_hit, is_ctrl;
    logic                   lk_req, lk_ext, lk_down, skip_load;
    logic                   hit, upd;
    logic [KEY_W-1:0]       hit_idx;

    assign rdy_rise = sync_q[SYNC_STAGES-1] & ~rdy_prev;
    assign tmo_hit  = (state != S_IDLE) && (tmo_cnt == TMO_LAST);
    assign is_ctrl  = (byte_q == 8'hAA) || (byte_q == 8'hFA) || (byte_q == 8'hFC) ||
                      (byte_q == 8'hFE) || (byte_q == 8'hEE) || (byte_q == 8'h00) ||
                      (byte_q == 8'hFF);

    always_ff @(posedge clk or negedge res) begin
        if (!res)           state <= S_IDLE;
        else if (clear_all) state <= S_IDLE;
        else                state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (proc_v) begin
            if (state == S_SKIP) begin
                state_nxt = (skip_cnt <= 3'd1) ? S_IDLE : S_SKIP;
            end else if (is_ctrl) begin
                state_nxt = S_IDLE;
            end else begin
                unique case (state)
                    S_IDLE: begin
                        if      (byte_q == 8'hF0) state_nxt = S_BRK;
                        else if (byte_q == 8'hE0) state_nxt = S_EXT;
                        else if (byte_q == 8'hE1) state_nxt = S_SKIP;
                        else                      state_nxt = S_IDLE;
                    end
                    S_EXT:   state_nxt = (byte_q == 8'hF0) ? S_EXTBRK : S_IDLE;
                    default: state_nxt = S_IDLE;
                endcase
            end
        end else if (tmo_hit) begin
            state_nxt = S_IDLE;
        end
    end

    always_comb begin
        lk_req    = 1'b0;
        lk_ext    = 1'b0;
        lk_down   = 1'b0;
        skip_load = 1'b0;
        if (proc_v && state != S_SKIP && !is_ctrl) begin
            unique case (state)
                S_IDLE: begin
                    lk_req    = (byte_q != 8'hF0) && (byte_q != 8'hE0) && (byte_q != 8'hE1);
                    lk_down   = 1'b1;
                    skip_load = (byte_q == 8'hE1);
                end
                S_EXT: begin
                    lk_req  = (byte_q != 8'hF0);
                    lk_ext  = 1'b1;
                    lk_down = 1'b1;
                end
                S_BRK:    lk_req = 1'b1;
                S_EXTBRK: begin
                    lk_req = 1'b1;
                    lk_ext = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Descending scan so the lowest matching entry is the one left in hit_idx.
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (KEYMAP[9*i +: 9] == {lk_ext, byte_q}) begin
                hit     = 1'b1;
                hit_idx = KEY_W'(i);
            end
        end
    end

    assign upd = lk_req && hit && (key_matrix[hit_idx] != lk_down);

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            sync_q     <= '0;
            rdy_prev   <= 1'b0;
            byte_q     <= 8'h00;
            proc_v     <= 1'b0;
            key_matrix <= '0;
            any_key    <= 1'b0;
            ev_valid   <= 1'b0;
            ev_key     <= '0;
            ev_down    <= 1'b0;
            tmo_cnt    <= '0;
            skip_cnt   <= 3'd0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], ps2_ready};
            rdy_prev <= sync_q[SYNC_STAGES-1];
            proc_v   <= rdy_rise & ~clear_all;
            if (rdy_rise) byte_q <= ps2_data;
            any_key  <= |key_matrix;
            if (clear_all) begin
                key_matrix <= '0;
                ev_valid   <= 1'b0;
                tmo_cnt    <= '0;
                skip_cnt   <= 3'd0;
            end else begin
                ev_valid <= upd;
                if (upd) begin
                    key_matrix[hit_idx] <= lk_down;
                    ev_key              <= hit_idx;
                    ev_down             <= lk_down;
                end
                if (proc_v || tmo_hit || state == S_IDLE) tmo_cnt <= '0;
                else                                      tmo_cnt <= tmo_cnt + 1'b1;
                if (skip_load)                    skip_cnt <= 3'd7;
                else if (proc_v && state == S_SKIP) skip_cnt <= skip_cnt - 1'b1;
                else if (tmo_hit)                 skip_cnt <= 3'd0;
            end
        end
    end
endmodule
